ex_mem_stage_skid: RTL and testbench
====================================

// Module: ex_mem_stage_skid
// PURPOSE
//   Parametrised EX->MEM pipeline stage with valid/ready handshake and a 2-entry skid buffer.
//   Carries WB control, M control, ALU result, store data and destination register from EX to MEM.
//   Supports back-pressure, flush to bubble and a saturating stall-cycle counter.
//   Control fields are forced to zero whenever no valid entry is presented, so a bubble never
//   writes memory or the register file.
// PARAMETERS
//   DATA_W      32  width of ALU result and store-data fields
//   REG_ADDR_W   5  width of destination register address
//   WB_W         2  width of WB control bundle (e.g. RegWrite, MemtoReg)
//   M_W          2  width of M control bundle (e.g. MemRead, MemWrite)
//   CNT_W       16  width of stall-cycle counter
// PORTS
//   clk_i         in   1           clock; all state updates on rising edge
//   rst_i         in   1           synchronous reset, active-high
//   flush_i       in   1           synchronous flush: discard all held entries
//   in_valid_i    in   1           EX presents a valid entry
//   in_ready_o    out  1           stage can accept an entry this cycle
//   WB_i          in   WB_W        WB control from EX
//   M_i           in   M_W         M control from EX
//   ALU_i         in   DATA_W      ALU result from EX
//   WriteData_i   in   DATA_W      store data from EX
//   RDaddr_i      in   REG_ADDR_W  destination register from EX
//   out_valid_o   out  1           MEM side sees a valid entry
//   out_ready_i   in   1           MEM side consumes the entry this cycle
//   WB_o          out  WB_W        WB control to MEM (0 when !out_valid_o)
//   M_o           out  M_W         M control to MEM (0 when !out_valid_o)
//   ALU_o         out  DATA_W      ALU result to MEM
//   WriteData_o   out  DATA_W      store data to MEM
//   RDaddr_o      out  REG_ADDR_W  destination register to MEM
//   stall_cnt_o   out  CNT_W       cycles with out_valid_o && !out_ready_i, saturating
// BEHAVIOUR
//   - Storage: main register (drives outputs) plus one skid register. State is EMPTY, ONE or TWO.
//   - Handshakes:
//     - accept = in_valid_i && in_ready_o; pop = out_valid_o && out_ready_i.
//     - in_ready_o = (state != TWO). It is a function of state only, never of out_ready_i.
//     - out_valid_o = (state != EMPTY).
//   - Transitions (no flush):
//     - EMPTY: accept -> ONE. Entry is loaded into main.
//     - ONE: accept && !pop -> TWO. Entry is loaded into skid.
//     - ONE: accept && pop -> ONE. Entry is loaded into main.
//     - ONE: !accept && pop -> EMPTY.
//     - TWO: pop -> ONE. Skid moves to main. No accept is possible in TWO.
//     - Otherwise the state and both registers hold.
//   - Latency: an entry accepted at edge N appears on the outputs after edge N (1 cycle) when the
//     stage is EMPTY or popping. Ordering is strictly FIFO.
//   - Output gating: WB_o and M_o equal the main-register fields when out_valid_o=1, else 0.
//     ALU_o, WriteData_o and RDaddr_o hold their last value when invalid.
//   - flush_i: next state is EMPTY regardless of accept or pop in the same cycle; the accepting
//     entry is dropped. Data registers are not cleared.
//   - rst_i: takes priority over flush_i. Next state is EMPTY and all data registers are cleared
//     to 0. stall_cnt_o is cleared to 0.
//   - While rst_i is high, in_ready_o=1 and out_valid_o=0. Inputs are ignored and no entry is
//     accepted.
//   - stall_cnt_o: increments by 1 when out_valid_o && !out_ready_i && !flush_i.
//     It saturates at 2^CNT_W-1 and never wraps. Only rst_i clears it.
//   - Simultaneous accept and pop in ONE keeps occupancy constant and sustains 1 entry per cycle.
//   - Widths are passed through unchanged. No arithmetic is performed on the data fields.
// TESTING
//   1. Stream: reset, then in_valid_i=1 and out_ready_i=1 for 8 cycles with ALU_i=0..7
//      -> ALU_o=0..7 on consecutive cycles, 1 cycle late; in_ready_o stays 1.
//   2. Back-pressure: out_ready_i=0, push A=0x11 and B=0x22
//      -> state TWO, in_ready_o=0, ALU_o=0x11.
//      Then out_ready_i=1 -> 0x11 popped, next cycle 0x22 shown, in_ready_o=1.
//   3. Bubble gating: with the stage empty, drive M_i=2'b11 and WB_i=2'b11 with in_valid_i=0
//      -> M_o=0, WB_o=0, out_valid_o=0.
//   4. Flush with accept: state ONE, in_valid_i=1 and flush_i=1 in the same cycle
//      -> next cycle out_valid_o=0; the flushed entry never appears.
//   5. Counter: CNT_W=3, out_valid_o=1 and out_ready_i=0 for 10 cycles
//      -> stall_cnt_o reaches 7 and holds at 7. rst_i -> 0.
//   6. Reset mid-operation: state TWO, assert rst_i for 1 cycle
//      -> out_valid_o=0, ALU_o=0, in_ready_o=1, stall_cnt_o=0.

Source files
------------

// File: rtl/ex_mem_stage_skid_if.sv
// EX->MEM handshake bundle: the EX-side producer fields and the MEM-side
// consumer fields of the pipeline stage, grouped into one interface.
interface ex_mem_stage_skid_if #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int WB_W       = 2,
    parameter int M_W        = 2
);
    // EX side
    logic                  in_valid_i;
    logic                  in_ready_o;
    logic [WB_W-1:0]       WB_i;
    logic [M_W-1:0]        M_i;
    logic [DATA_W-1:0]     ALU_i;
    logic [DATA_W-1:0]     WriteData_i;
    logic [REG_ADDR_W-1:0] RDaddr_i;

    // MEM side
    logic                  out_valid_o;
    logic                  out_ready_i;
    logic [WB_W-1:0]       WB_o;
    logic [M_W-1:0]        M_o;
    logic [DATA_W-1:0]     ALU_o;
    logic [DATA_W-1:0]     WriteData_o;
    logic [REG_ADDR_W-1:0] RDaddr_o;

    // Environment view: drives EX fields and MEM ready, observes the stage
    modport master (
        output in_valid_i, WB_i, M_i, ALU_i, WriteData_i, RDaddr_i, out_ready_i,
        input  in_ready_o, out_valid_o, WB_o, M_o, ALU_o, WriteData_o, RDaddr_o
    );

    // Stage view
    modport slave (
        input  in_valid_i, WB_i, M_i, ALU_i, WriteData_i, RDaddr_i, out_ready_i,
        output in_ready_o, out_valid_o, WB_o, M_o, ALU_o, WriteData_o, RDaddr_o
    );
endinterface

// File: rtl/ex_mem_stage_skid.sv
// EX->MEM pipeline register with valid/ready handshake and a 2-entry skid
// buffer (main register drives the outputs, skid absorbs one extra entry so
// in_ready_o never depends combinationally on out_ready_i). Also keeps a
// saturating count of cycles where MEM stalls a valid entry.
module ex_mem_stage_skid #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int WB_W       = 2,
    parameter int M_W        = 2,
    parameter int CNT_W      = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    ex_mem_stage_skid_if.slave bus,
    output logic [CNT_W-1:0]  stall_cnt_o
);

    typedef struct packed {
        logic [WB_W-1:0]       wb;
        logic [M_W-1:0]        m;
        logic [DATA_W-1:0]     alu;
        logic [DATA_W-1:0]     wdata;
        logic [REG_ADDR_W-1:0] rd;
    } entry_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t     state_q, state_d;
    entry_t     main_q, skid_q, in_entry;
    logic       accept, pop;
    logic       load_main_in, load_main_skid, load_skid;

    assign in_entry = '{wb: bus.WB_i, m: bus.M_i, alu: bus.ALU_i,
                        wdata: bus.WriteData_i, rd: bus.RDaddr_i};

    // During reset the stage advertises ready but shows nothing and takes nothing
    assign bus.in_ready_o  = rst_i || (state_q != TWO);
    assign bus.out_valid_o = !rst_i && (state_q != EMPTY);
    assign accept          = bus.in_valid_i && bus.in_ready_o && !rst_i;
    assign pop             = bus.out_valid_o && bus.out_ready_i;

    // Next-state and register-load decisions; flush overrides everything
    always_comb begin
        state_d        = state_q;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        case (state_q)
            EMPTY: begin
                if (accept) begin
                    state_d      = ONE;
                    load_main_in = 1'b1;
                end
            end
            ONE: begin
                if (accept && !pop) begin
                    state_d   = TWO;
                    load_skid = 1'b1;
                end else if (accept && pop) begin
                    load_main_in = 1'b1;
                end else if (pop) begin
                    state_d = EMPTY;
                end
            end
            TWO: begin
                if (pop) begin
                    state_d        = ONE;
                    load_main_skid = 1'b1;
                end
            end
            default: state_d = EMPTY;
        endcase
        if (flush_i) begin
            state_d        = EMPTY;
            load_main_in   = 1'b0;
            load_main_skid = 1'b0;
            load_skid      = 1'b0;
        end
    end

    // Occupancy state register
    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= EMPTY;
        else       state_q <= state_d;
    end

    // Main and skid data registers; flush leaves their contents untouched
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            if (load_main_in)        main_q <= in_entry;
            else if (load_main_skid) main_q <= skid_q;
            if (load_skid)           skid_q <= in_entry;
        end
    end

    // Saturating stall-cycle counter; only reset clears it
    always_ff @(posedge clk_i) begin
        if (rst_i)
            stall_cnt_o <= '0;
        else if (bus.out_valid_o && !bus.out_ready_i && !flush_i && stall_cnt_o != CNT_MAX)
            stall_cnt_o <= stall_cnt_o + 1'b1;
    end

    // Control bundles are gated so a bubble never writes memory or registers
    assign bus.WB_o        = bus.out_valid_o ? main_q.wb : '0;
    assign bus.M_o         = bus.out_valid_o ? main_q.m  : '0;
    assign bus.ALU_o       = main_q.alu;
    assign bus.WriteData_o = main_q.wdata;
    assign bus.RDaddr_o    = main_q.rd;

endmodule

// File: tb/tb_ex_mem_stage_skid.sv
// Bench for ex_mem_stage_skid: directed scenarios plus a random run, all
// compared against a queue-based reference model of a 2-deep FIFO stage.
module tb_ex_mem_stage_skid;

    localparam int DATA_W     = 32;
    localparam int REG_ADDR_W = 5;
    localparam int WB_W       = 2;
    localparam int M_W        = 2;
    localparam int CNT_W      = 3;
    localparam int CNT_MAX    = 7;
    localparam int OW         = 2 + WB_W + M_W + 2*DATA_W + REG_ADDR_W + CNT_W;

    typedef struct packed {
        logic [WB_W-1:0]       wb;
        logic [M_W-1:0]        m;
        logic [DATA_W-1:0]     alu;
        logic [DATA_W-1:0]     wd;
        logic [REG_ADDR_W-1:0] rd;
    } ent_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic flush = 1'b0;
    logic [CNT_W-1:0] stall_cnt;

    int errors = 0;
    int checks = 0;

    // Reference model state
    ent_t q[$];
    ent_t last_front = '0;
    int   cnt_m = 0;

    ex_mem_stage_skid_if #(.DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W),
                           .WB_W(WB_W), .M_W(M_W)) bus ();

    ex_mem_stage_skid #(.DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W), .WB_W(WB_W),
                        .M_W(M_W), .CNT_W(CNT_W)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .flush_i    (flush),
        .bus        (bus),
        .stall_cnt_o(stall_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [OW-1:0] model_out();
        logic v;
        logic [CNT_W-1:0] c;
        v = (q.size() != 0);
        c = cnt_m[CNT_W-1:0];
        return {(q.size() < 2), v,
                v ? last_front.wb : {WB_W{1'b0}},
                v ? last_front.m  : {M_W{1'b0}},
                last_front.alu, last_front.wd, last_front.rd, c};
    endfunction

    function automatic logic [OW-1:0] dut_out();
        return {bus.in_ready_o, bus.out_valid_o, bus.WB_o, bus.M_o, bus.ALU_o,
                bus.WriteData_o, bus.RDaddr_o, stall_cnt};
    endfunction

    task automatic set_in(input logic v, input logic [DATA_W-1:0] alu);
        bus.in_valid_i  = v;
        bus.ALU_i       = alu;
        bus.WB_i        = WB_W'($urandom);
        bus.M_i         = M_W'($urandom);
        bus.WriteData_i = $urandom;
        bus.RDaddr_i    = REG_ADDR_W'($urandom);
    endtask

    // One clock: model updates from the inputs seen at the edge, then we
    // return at the following falling edge where outputs are sampled.
    task automatic step();
        logic acc, pop;
        ent_t e;
        @(posedge clk);
        e   = '{wb: bus.WB_i, m: bus.M_i, alu: bus.ALU_i, wd: bus.WriteData_i, rd: bus.RDaddr_i};
        acc = !rst && bus.in_valid_i && (q.size() < 2);
        pop = !rst && (q.size() != 0) && bus.out_ready_i;
        if (rst) begin
            q.delete();
            last_front = '0;
            cnt_m = 0;
        end else begin
            if (q.size() != 0 && !bus.out_ready_i && !flush && cnt_m < CNT_MAX) cnt_m++;
            if (flush) begin
                q.delete();
            end else begin
                if (pop) void'(q.pop_front());
                if (acc) q.push_back(e);
            end
            if (q.size() != 0) last_front = q[0];
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        flush = 1'b0;
        set_in(1'b0, '0);
        bus.out_ready_i = 1'b0;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        flush = 1'b0;
        bus.out_ready_i = 1'b1;
        set_in(1'b1, 32'hDEAD_BEEF);
        step();
        step();
        checks++;
        if (bus.in_ready_o !== 1'b1 || bus.out_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_hs: ready=%b valid=%b required ready=1 valid=0", bus.in_ready_o, bus.out_valid_o);
        end
        checks++;
        if (bus.ALU_o !== '0 || stall_cnt !== '0 || bus.WB_o !== '0 || bus.M_o !== '0) begin
            errors++;
            $display("FAIL reset_data: alu=%h cnt=%0d wb=%b m=%b required all 0", bus.ALU_o, stall_cnt, bus.WB_o, bus.M_o);
        end
        rst = 1'b0;
        set_in(1'b0, '0);
        step();
        checks++;
        if (bus.out_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_no_accept: valid=%b required 0", bus.out_valid_o);
        end
    endtask

    task automatic test_stream();
        do_reset();
        bus.out_ready_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            set_in(1'b1, DATA_W'(i));
            step();
            checks++;
            if (bus.ALU_o !== DATA_W'(i) || bus.out_valid_o !== 1'b1 || bus.in_ready_o !== 1'b1) begin
                errors++;
                $display("FAIL stream[%0d]: alu=%h valid=%b ready=%b required alu=%h valid=1 ready=1",
                         i, bus.ALU_o, bus.out_valid_o, bus.in_ready_o, i);
            end
            checks++;
            if (dut_out() !== model_out()) begin
                errors++;
                $display("FAIL stream_model[%0d]: got=%h exp=%h", i, dut_out(), model_out());
            end
        end
        set_in(1'b0, '0);
        step();
    endtask

    task automatic test_back_pressure();
        do_reset();
        bus.out_ready_i = 1'b0;
        set_in(1'b1, 32'h11);
        step();
        set_in(1'b1, 32'h22);
        step();
        set_in(1'b0, '0);
        checks++;
        if (bus.in_ready_o !== 1'b0 || bus.ALU_o !== 32'h11 || bus.out_valid_o !== 1'b1) begin
            errors++;
            $display("FAIL bp_full: ready=%b alu=%h valid=%b required ready=0 alu=11 valid=1",
                     bus.in_ready_o, bus.ALU_o, bus.out_valid_o);
        end
        checks++;
        if (dut_out() !== model_out()) begin
            errors++;
            $display("FAIL bp_full_model: got=%h exp=%h", dut_out(), model_out());
        end
        bus.out_ready_i = 1'b1;
        step();
        checks++;
        if (bus.ALU_o !== 32'h22 || bus.in_ready_o !== 1'b1 || bus.out_valid_o !== 1'b1) begin
            errors++;
            $display("FAIL bp_drain: alu=%h ready=%b valid=%b required alu=22 ready=1 valid=1",
                     bus.ALU_o, bus.in_ready_o, bus.out_valid_o);
        end
        step();
        checks++;
        if (bus.out_valid_o !== 1'b0 || dut_out() !== model_out()) begin
            errors++;
            $display("FAIL bp_empty: got=%h exp=%h", dut_out(), model_out());
        end
    endtask

    task automatic test_bubble_gating();
        do_reset();
        bus.out_ready_i = 1'b1;
        set_in(1'b0, 32'h55);
        bus.M_i = 2'b11;
        bus.WB_i = 2'b11;
        step();
        step();
        checks++;
        if (bus.M_o !== 2'b00 || bus.WB_o !== 2'b00 || bus.out_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL bubble: m=%b wb=%b valid=%b required m=00 wb=00 valid=0",
                     bus.M_o, bus.WB_o, bus.out_valid_o);
        end
    endtask

    task automatic test_flush_accept();
        do_reset();
        bus.out_ready_i = 1'b0;
        set_in(1'b1, 32'hA5);
        step();
        set_in(1'b1, 32'h5A);
        flush = 1'b1;
        step();
        flush = 1'b0;
        set_in(1'b0, '0);
        checks++;
        if (bus.out_valid_o !== 1'b0 || bus.in_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL flush_state: valid=%b ready=%b required valid=0 ready=1", bus.out_valid_o, bus.in_ready_o);
        end
        bus.out_ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (bus.out_valid_o !== 1'b0 || bus.ALU_o !== 32'hA5) begin
                errors++;
                $display("FAIL flush_drop[%0d]: valid=%b alu=%h required valid=0 alu=a5",
                         i, bus.out_valid_o, bus.ALU_o);
            end
        end
    endtask

    task automatic test_counter();
        do_reset();
        bus.out_ready_i = 1'b0;
        set_in(1'b1, 32'h77);
        step();
        set_in(1'b0, '0);
        for (int i = 0; i < 10; i++) step();
        checks++;
        if (stall_cnt !== 3'd7) begin
            errors++;
            $display("FAIL cnt_sat: cnt=%0d required 7", stall_cnt);
        end
        step();
        checks++;
        if (stall_cnt !== 3'd7 || dut_out() !== model_out()) begin
            errors++;
            $display("FAIL cnt_hold: cnt=%0d required 7", stall_cnt);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if (stall_cnt !== 3'd0) begin
            errors++;
            $display("FAIL cnt_reset: cnt=%0d required 0", stall_cnt);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        bus.out_ready_i = 1'b0;
        set_in(1'b1, 32'h3C);
        step();
        set_in(1'b1, 32'h4D);
        step();
        rst = 1'b1;
        set_in(1'b1, 32'h99);
        step();
        checks++;
        if (bus.out_valid_o !== 1'b0 || bus.ALU_o !== 32'h0 || bus.in_ready_o !== 1'b1 || stall_cnt !== 3'd0) begin
            errors++;
            $display("FAIL reset_mid: valid=%b alu=%h ready=%b cnt=%0d required valid=0 alu=0 ready=1 cnt=0",
                     bus.out_valid_o, bus.ALU_o, bus.in_ready_o, stall_cnt);
        end
        rst = 1'b0;
        set_in(1'b0, '0);
        step();
        checks++;
        if (dut_out() !== model_out()) begin
            errors++;
            $display("FAIL reset_mid_after: got=%h exp=%h", dut_out(), model_out());
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            set_in($urandom_range(0, 3) != 0, $urandom);
            bus.out_ready_i = ($urandom_range(0, 2) != 0);
            flush = ($urandom_range(0, 15) == 0);
            rst   = ($urandom_range(0, 63) == 0);
            step();
            checks++;
            if (dut_out() !== model_out()) begin
                errors++;
                $display("FAIL random[%0d]: got=%h exp=%h", i, dut_out(), model_out());
            end
        end
        flush = 1'b0;
        rst = 1'b0;
    endtask

    initial begin
        bus.out_ready_i = 1'b0;
        set_in(1'b0, '0);
        @(negedge clk);
        test_reset();
        test_stream();
        test_back_pressure();
        test_bubble_gating();
        test_flush_accept();
        test_counter();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
